// File: rtl/prbs_sim_monitor.sv
// PRBS7 bit-error monitor: self-seeds a checker from the received bit stream.
// It discards a settling window after lock and then counts errors over a fixed
// measurement window. It raises a sticky sim_done when that window completes.
module prbs_sim_monitor #(
    parameter int unsigned SETTLE_BITS  = 1000,
    parameter int unsigned MEASURE_BITS = 100000,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic                 rx_bit,
    output logic                 locked,
    output logic                 measuring,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 sim_done
);

    // The window counters are sized from the parameters, not from CNT_WIDTH.
    // This lets the window still end when the reported counts saturate early.
    localparam int unsigned SetW  = (SETTLE_BITS > 1) ? $clog2(SETTLE_BITS + 1) : 1;
    localparam int unsigned MeasW = (MEASURE_BITS > 1) ? $clog2(MEASURE_BITS + 1) : 1;

    localparam logic [SetW-1:0]      SetLast  = SetW'(SETTLE_BITS - 1);
    localparam logic [MeasW-1:0]     MeasLast = MeasW'(MEASURE_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    typedef enum logic [1:0] {
        StSeed,
        StSettle,
        StMeasure,
        StDone
    } state_t;

    state_t           state;
    logic [6:0]       sreg;
    logic [2:0]       seed_cnt;
    logic [SetW-1:0]  settle_cnt;
    logic [MeasW-1:0] meas_cnt;
    logic             pred;
    logic [6:0]       seed_next;
    logic [6:0]       pred_next;

    // PRBS7 (x^7 + x^6 + 1) prediction and the two shift-register update forms
    always_comb begin
        pred      = sreg[6] ^ sreg[5];
        seed_next = {sreg[5:0], rx_bit};
        pred_next = {sreg[5:0], pred};
    end

    // Checker FSM; every output is a register updated only on accepted strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StSeed;
            sreg       <= '0;
            seed_cnt   <= '0;
            settle_cnt <= '0;
            meas_cnt   <= '0;
            locked     <= 1'b0;
            measuring  <= 1'b0;
            bit_count  <= '0;
            err_count  <= '0;
            sim_done   <= 1'b0;
        end else if (rx_valid) begin
            case (state)
                StSeed: begin
                    sreg <= seed_next;
                    if (seed_cnt == 3'd6) begin
                        seed_cnt <= '0;
                        // An all-zero seed locks the LFSR; stay and reseed
                        if (seed_next != 7'd0) begin
                            locked <= 1'b1;
                            if (SETTLE_BITS == 0) begin
                                state     <= StMeasure;
                                measuring <= 1'b1;
                            end else begin
                                state <= StSettle;
                            end
                        end
                    end else begin
                        seed_cnt <= seed_cnt + 3'd1;
                    end
                end

                StSettle: begin
                    if (rx_bit != pred) begin
                        // Lost alignment: start over from a fresh seed
                        state      <= StSeed;
                        sreg       <= '0;
                        seed_cnt   <= '0;
                        settle_cnt <= '0;
                        locked     <= 1'b0;
                    end else begin
                        sreg <= pred_next;
                        if (settle_cnt == SetLast) begin
                            state      <= StMeasure;
                            measuring  <= 1'b1;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                StMeasure: begin
                    // Free-running predictor: a flipped bit costs exactly one error
                    sreg <= pred_next;
                    if (bit_count != CntMax) begin
                        bit_count <= bit_count + 1'b1;
                    end
                    if ((rx_bit != pred) && (err_count != CntMax)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (meas_cnt == MeasLast) begin
                        state     <= StDone;
                        measuring <= 1'b0;
                        sim_done  <= 1'b1;
                    end else begin
                        meas_cnt <= meas_cnt + 1'b1;
                    end
                end

                StDone: begin
                    // Frozen until reset
                end

                default: begin
                    state <= StSeed;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_sim_monitor.sv
// Bench for prbs_sim_monitor: scoreboard of per-strobe expectations from a
// history-based PRBS7 reference model, plus directed checks for the test plan.
module tb_prbs_sim_monitor;

    localparam int SB   = 20;
    localparam int MB   = 100;
    localparam int CW   = 32;
    localparam int MB_B = 20;
    localparam int CW_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_valid = 1'b0;
    logic rx_bit = 1'b0;
    logic locked, measuring, sim_done;
    logic [CW-1:0] bit_count, err_count;

    logic b_valid = 1'b0;
    logic b_bit = 1'b0;
    logic b_locked, b_measuring, b_done;
    logic [CW_B-1:0] b_bits, b_errs;

    always #5 clk = ~clk;

    prbs_sim_monitor #(.SETTLE_BITS(SB), .MEASURE_BITS(MB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_bit(rx_bit),
        .locked(locked), .measuring(measuring), .bit_count(bit_count),
        .err_count(err_count), .sim_done(sim_done)
    );

    prbs_sim_monitor #(.SETTLE_BITS(SB), .MEASURE_BITS(MB_B), .CNT_WIDTH(CW_B)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(b_valid), .rx_bit(b_bit),
        .locked(b_locked), .measuring(b_measuring), .bit_count(b_bits),
        .err_count(b_errs), .sim_done(b_done)
    );

    typedef struct packed {
        logic        lk;
        logic        ms;
        logic [31:0] bits;
        logic [31:0] errs;
        logic        dn;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    bit   gen[127];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 seeding, 1 settling, 2 measuring, 3 done.
    // Prediction comes from the history of accepted/predicted bits.
    int m_phase, m_nset, m_nmeas, m_nerr;
    bit m_hist[$];

    function automatic void m_reset();
        m_phase = 0;
        m_nset  = 0;
        m_nmeas = 0;
        m_nerr  = 0;
        m_hist.delete();
    endfunction

    function automatic void m_step(bit b);
        bit p;
        int ones;
        if (m_phase == 0) begin
            m_hist.push_back(b);
            if (m_hist.size() == 7) begin
                ones = 0;
                foreach (m_hist[i]) ones += int'(m_hist[i]);
                if (ones == 0) m_hist.delete();
                else m_phase = (SB == 0) ? 2 : 1;
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            p = m_hist[m_hist.size() - 7] ^ m_hist[m_hist.size() - 6];
            if (m_phase == 1) begin
                if (b != p) begin
                    m_phase = 0;
                    m_nset  = 0;
                    m_hist.delete();
                end else begin
                    m_hist.push_back(p);
                    m_nset++;
                    if (m_nset == SB) m_phase = 2;
                end
            end else begin
                m_hist.push_back(p);
                m_nmeas++;
                if (b != p) m_nerr++;
                if (m_nmeas == MB) m_phase = 3;
            end
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        longint cmax = (longint'(1) << CW) - 1;
        e.lk   = (m_phase != 0);
        e.ms   = (m_phase == 2);
        e.bits = 32'((m_nmeas > cmax) ? cmax : m_nmeas);
        e.errs = 32'((m_nerr > cmax) ? cmax : m_nerr);
        e.dn   = (m_phase == 3);
        return e;
    endfunction

    // Monitor: after every clock edge that took a strobe, pop and compare
    logic v_seen = 1'b0;
    always @(posedge clk) v_seen <= rx_valid;

    always @(negedge clk) begin
        exp_t e;
        if (v_seen) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("locked", locked, e.lk);
                chk("measuring", measuring, e.ms);
                chk("bit_count", bit_count, e.bits);
                chk("err_count", err_count, e.errs);
                chk("sim_done", sim_done, e.dn);
            end
        end
    end

    task automatic drive(input bit v, input bit b);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_bit   = v ? b : 1'($urandom);
        if (v) begin
            m_step(b);
            sbq.push_back(m_expect());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic run_stream(input int n, input int bad_idx, input int offset, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) idle(gap);
            drive(1'b1, gen[(i + offset) % 127] ^ (i == bad_idx));
        end
        idle(1);
    endtask

    // Asynchronous reset pulse between clock edges, after the scoreboard drains
    task automatic do_reset();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        rst = 1'b1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_measuring", measuring, 0);
        chk("rst_bits", bit_count, 0);
        chk("rst_errs", err_count, 0);
        chk("rst_done", sim_done, 0);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic final_chk(input string name, input int bits, input int errs);
        chk({name, "_done"}, sim_done, 1);
        chk({name, "_bits"}, bit_count, bits);
        chk({name, "_errs"}, err_count, errs);
        chk({name, "_measuring"}, measuring, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        for (int n = 0; n < 7; n++) gen[n] = 1'b1;
        for (int n = 7; n < 127; n++) gen[n] = gen[n - 7] ^ gen[n - 6];
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("init_locked", locked, 0);
        chk("init_measuring", measuring, 0);
        chk("init_bits", bit_count, 0);
        chk("init_errs", err_count, 0);
        chk("init_done", sim_done, 0);
        chk("init_b_done", b_done, 0);
        rst = 1'b0;

        // Clean stream, seed 7'h7F, strobe every cycle
        run_stream(127, -1, 0, 0);
        final_chk("clean", MB, 0);
        chk("clean_locked", locked, 1);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'($urandom));
        idle(1);
        chk("frozen_bits", bit_count, MB);
        chk("frozen_errs", err_count, 0);
        chk("frozen_done", sim_done, 1);

        // Measurement-window bit 60 inverted (overall bit 87)
        do_reset();
        run_stream(127, 86, 0, 0);
        final_chk("meas_err", MB, 1);

        // Settle bit 10 inverted (overall bit 17): relock, done at 144 bits
        do_reset();
        run_stream(143, 16, 0, 0);
        chk("relock_not_done", sim_done, 0);
        run_stream(1, -1, 143, 0);
        final_chk("relock", MB, 0);

        // 14 zeros never lock, then a clean stream completes normally
        do_reset();
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b0);
        idle(1);
        chk("zeros_unlocked", locked, 0);
        off = $urandom_range(0, 126);
        run_stream(127, -1, off, 0);
        final_chk("after_zeros", MB, 0);

        // One strobe in three, async reset mid-measure, then a full run
        do_reset();
        run_stream(60, -1, 0, 2);
        chk("mid_measuring", measuring, 1);
        do_reset();
        off = $urandom_range(0, 126);
        run_stream(127, -1, off, 2);
        final_chk("gapped", MB, 0);

        // Random gaps and random bit flips against the model
        do_reset();
        off = $urandom_range(0, 126);
        for (int i = 0; i < 600; i++) begin
            idle($urandom_range(0, 2));
            drive(1'b1, gen[(i + off) % 127] ^ ($urandom_range(0, 99) < 3));
        end
        idle(2);

        // Narrow counters: 20 inverted measurement bits saturate at 15
        for (int i = 0; i < 27 + MB_B; i++) begin
            @(posedge clk);
            #1;
            b_valid = 1'b1;
            b_bit   = (i < 27) ? gen[i] : ~gen[i % 127];
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        chk("sat_done", b_done, 1);
        chk("sat_errs", b_errs, 15);
        chk("sat_bits", b_bits, 15);
        chk("sat_locked", b_locked, 1);
        chk("sat_measuring", b_measuring, 0);

        idle(2);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
